// File: rtl/demux_out_slot.sv
/* ------------------------------------------------------------------
 * demux_out_slot : one-entry output register with transfer counter
 * Revision: 1.0
 * ------------------------------------------------------------------ */
`default_nettype none

module demux_out_slot #(
  parameter int size  = 32,
  parameter int cnt_w = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [size-1:0]  wr_data_i,
  output logic             accept_o,
  output logic [size-1:0]  data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [cnt_w-1:0] count_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q, state_d;
  logic [size-1:0]  data_q, data_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             out_xfer;

  assign out_xfer = (state_q == FULL) && ready_i;
  // A full slot can take new data in the same cycle it drains.
  assign accept_o = (state_q == EMPTY) || ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (wr_i) begin
      state_d = FULL;
      data_d  = wr_data_i;
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
    if (out_xfer) begin
      count_d = count_q + 1'b1;
    end
  end

  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stream_demux_1to2.sv
/* ------------------------------------------------------------------
 * stream_demux_1to2 : routes a valid/ready stream to one of two slots
 * Revision: 1.0
 * ------------------------------------------------------------------ */
`default_nettype none

module stream_demux_1to2 #(
  parameter int size  = 32,
  parameter int cnt_w = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [size-1:0]  data1_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [cnt_w-1:0] count0_o,
  output logic [cnt_w-1:0] count1_o
);

  logic accept0, accept1;
  logic wr0, wr1;

  // Only the selected slot gates the input; the other may stall freely.
  assign ready_o = select_i ? accept1 : accept0;
  assign wr0     = valid_i && ready_o && !select_i;
  assign wr1     = valid_i && ready_o &&  select_i;

  demux_out_slot #(.size(size), .cnt_w(cnt_w)) u_slot0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (wr0),
    .wr_data_i (data_i),
    .accept_o  (accept0),
    .data_o    (data0_o),
    .valid_o   (valid0_o),
    .ready_i   (ready0_i),
    .count_o   (count0_o)
  );

  demux_out_slot #(.size(size), .cnt_w(cnt_w)) u_slot1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (wr1),
    .wr_data_i (data_i),
    .accept_o  (accept1),
    .data_o    (data1_o),
    .valid_o   (valid1_o),
    .ready_i   (ready1_i),
    .count_o   (count1_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
/* ------------------------------------------------------------------
 * tb_stream_demux_1to2 : directed self-checking bench
 * Revision: 1.0
 * ------------------------------------------------------------------ */
`default_nettype none

module tb_stream_demux_1to2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic        select_i, valid_i, ready0_i, ready1_i;
  logic        ready_o, valid0_o, valid1_o;
  logic [31:0] data0_o, data1_o;
  logic [7:0]  count0_o, count1_o;
  logic        w_ready, w_valid0, w_valid1;
  logic [31:0] w_data0, w_data1;
  logic [1:0]  w_count0, w_count1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .data0_o(data0_o), .valid0_o(valid0_o), .ready0_i(ready0_i),
    .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(ready1_i),
    .count0_o(count0_o), .count1_o(count1_o)
  );

  stream_demux_1to2 #(.size(32), .cnt_w(2)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
    .valid_i(valid_i), .ready_o(w_ready),
    .data0_o(w_data0), .valid0_o(w_valid0), .ready0_i(ready0_i),
    .data1_o(w_data1), .valid1_o(w_valid1), .ready1_i(ready1_i),
    .count0_o(w_count0), .count1_o(w_count1)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b0; valid_i = 1'b0; select_i = 1'b0; data_i = '0;
    step();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; valid_i = 1'b0; select_i = 1'b0; data_i = '0;
    ready0_i = 1'b1; ready1_i = 1'b1;
    step(); step();
    #1;
    checks++; if (valid0_o !== 1'b0) begin errors++; $display("FAIL reset_valid0 got=%0b exp=0", valid0_o); end
    checks++; if (valid1_o !== 1'b0) begin errors++; $display("FAIL reset_valid1 got=%0b exp=0", valid1_o); end
    checks++; if (data0_o !== 32'h0 || data1_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", data0_o, data1_o); end
    checks++; if (count0_o !== 8'd0 || count1_o !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d/%0d exp=0/0", count0_o, count1_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
    rst_i = 1'b1;
  endtask

  task automatic test_basic();
    ready0_i = 1'b0; ready1_i = 1'b0;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'hA5A5_0001;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready got=%0b exp=1", ready_o); end
    step();
    valid_i = 1'b0;
    #1;
    checks++; if (valid0_o !== 1'b1) begin errors++; $display("FAIL basic_valid0 got=%0b exp=1", valid0_o); end
    checks++; if (data0_o !== 32'hA5A5_0001) begin errors++; $display("FAIL basic_data0 got=%h exp=a5a50001", data0_o); end
    checks++; if (valid1_o !== 1'b0) begin errors++; $display("FAIL basic_valid1 got=%0b exp=0", valid1_o); end
  endtask

  task automatic test_nonblocking_select();
    ready0_i = 1'b1;
    step();
    ready0_i = 1'b0;
    #1;
    checks++; if (valid0_o !== 1'b0 || count0_o !== 8'd1) begin errors++; $display("FAIL drain0 got valid=%0b cnt=%0d exp valid=0 cnt=1", valid0_o, count0_o); end
    valid_i = 1'b1; select_i = 1'b1; data_i = 32'hB000_0001;
    step();
    data_i = 32'hB000_0002;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stalled1_ready got=%0b exp=0", ready_o); end
    step();
    #1;
    checks++; if (data1_o !== 32'hB000_0001 || valid1_o !== 1'b1) begin errors++; $display("FAIL stalled1_hold got=%h/%0b exp=b0000001/1", data1_o, valid1_o); end
    select_i = 1'b0; data_i = 32'hC000_0001;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL sel0_ready got=%0b exp=1", ready_o); end
    step();
    valid_i = 1'b0;
    #1;
    checks++; if (valid0_o !== 1'b1 || data0_o !== 32'hC000_0001) begin errors++; $display("FAIL sel0_accept got=%0b/%h exp=1/c0000001", valid0_o, data0_o); end
    checks++; if (data1_o !== 32'hB000_0001) begin errors++; $display("FAIL ch1_untouched got=%h exp=b0000001", data1_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [5];
    vals[0] = 32'hD000_0000; vals[1] = 32'hD000_0011; vals[2] = 32'hD000_0022;
    vals[3] = 32'hD000_0033; vals[4] = 32'hD000_0044;
    ready0_i = 1'b0; ready1_i = 1'b0;
    do_reset();
    valid_i = 1'b1; select_i = 1'b0; data_i = vals[0];
    step();
    for (int k = 0; k < 4; k++) begin
      ready0_i = 1'b1; data_i = vals[k+1];
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", k, ready_o); end
      checks++; if (data0_o !== vals[k] || valid0_o !== 1'b1) begin errors++; $display("FAIL b2b_order[%0d] got=%h/%0b exp=%h/1", k, data0_o, valid0_o, vals[k]); end
      step();
    end
    valid_i = 1'b0; ready0_i = 1'b0;
    #1;
    checks++; if (count0_o !== 8'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", count0_o); end
    checks++; if (data0_o !== vals[4]) begin errors++; $display("FAIL b2b_last got=%h exp=%h", data0_o, vals[4]); end
  endtask

  task automatic test_stall();
    ready0_i = 1'b1;
    step();
    ready0_i = 1'b0;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'hE000_00E0;
    step();
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      checks++; if (data0_o !== 32'hE000_00E0 || valid0_o !== 1'b1 || count0_o !== 8'd5) begin
        errors++; $display("FAIL stall[%0d] got=%h/%0b/%0d exp=e00000e0/1/5", k, data0_o, valid0_o, count0_o);
      end
    end
    ready0_i = 1'b1;
    step(); step();
    #1;
    checks++; if (count0_o !== 8'd6 || valid0_o !== 1'b0) begin errors++; $display("FAIL stall_release got=%0d/%0b exp=6/0", count0_o, valid0_o); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w [5];
    exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0; exp_w[4] = 2'd1;
    ready0_i = 1'b0; ready1_i = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      valid_i = 1'b1; select_i = 1'b1; data_i = 32'h1000 + k;
      step();
      valid_i = 1'b0;
      step();
      #1;
      checks++; if (w_count1 !== exp_w[k]) begin errors++; $display("FAIL wrap_count1[%0d] got=%0d exp=%0d", k, w_count1, exp_w[k]); end
    end
    checks++; if (count1_o !== 8'd5) begin errors++; $display("FAIL wide_count1 got=%0d exp=5", count1_o); end
  endtask

  task automatic test_reset_flush();
    ready0_i = 1'b0; ready1_i = 1'b0;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'hF000_0000;
    step();
    select_i = 1'b1; data_i = 32'hF000_0001;
    step();
    #1;
    checks++; if (valid0_o !== 1'b1 || valid1_o !== 1'b1) begin errors++; $display("FAIL flush_prefill got=%0b/%0b exp=1/1", valid0_o, valid1_o); end
    rst_i = 1'b0; select_i = 1'b0; data_i = 32'h9999_9999; ready0_i = 1'b1;
    step();
    rst_i = 1'b1; valid_i = 1'b0; ready0_i = 1'b0;
    #1;
    checks++; if (valid0_o !== 1'b0 || valid1_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b/%0b exp=0/0", valid0_o, valid1_o); end
    checks++; if (count0_o !== 8'd0 || count1_o !== 8'd0) begin errors++; $display("FAIL flush_count got=%0d/%0d exp=0/0", count0_o, count1_o); end
    checks++; if (data0_o !== 32'h0 || data1_o !== 32'h0) begin errors++; $display("FAIL flush_data got=%h/%h exp=0/0", data0_o, data1_o); end
    step();
    #1;
    checks++; if (valid0_o !== 1'b0) begin errors++; $display("FAIL flush_no_accept got=%0b exp=0", valid0_o); end
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; select_i = 1'b0; data_i = '0;
    ready0_i = 1'b0; ready1_i = 1'b0;
    step();
    test_reset();
    test_basic();
    test_nonblocking_select();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 Parameter: size, default 32, data width in bits of input and both output channels.
REQ-002 Parameter: cnt_w, default 8, width of each per-channel transfer counter.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 Port: data_i  input  size  input payload.
REQ-006 Port: select_i  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
REQ-007 Port: valid_i  input  1  input payload and select_i are valid.
REQ-008 Port: ready_o  output  1  block accepts the input this cycle.
REQ-009 Port: data0_o  output  size  channel-0 payload.
REQ-010 Port: valid0_o  output  1  channel-0 payload valid.
REQ-011 Port: ready0_i  input  1  channel-0 consumer accepts.
REQ-012 Port: data1_o / valid1_o / ready1_i  output/output/input  size/1/1  channel-1 equivalents.
REQ-013 Port: count0_o, count1_o  output  cnt_w  completed output transfers per channel.

Function
REQ-014 Input transfer SHALL occur when valid_i && ready_o are both 1 at a rising edge; output transfer on channel k SHALL occur when validk_o && readyk_i are both 1.
REQ-015 Each channel SHALL hold a one-entry output register (slot) with states EMPTY and FULL; validk_o = (slot k FULL); datak_o = slot k data.
REQ-016 ready_o SHALL be combinational: slot[select_i] EMPTY, or slot[select_i] FULL && ready[select_i]_i (drain-and-refill same cycle).
REQ-017 ready_o SHALL depend only on the selected slot; a stalled non-selected channel SHALL NOT block input.
REQ-018 Slot transitions: EMPTY->FULL on input transfer to it; FULL->EMPTY on output transfer with no input transfer to it; FULL->FULL (data replaced) on simultaneous output and input transfer; otherwise hold.
REQ-019 Latency: data accepted at edge N SHALL appear on datak_o with validk_o = 1 after edge N (one cycle).
REQ-020 While validk_o = 1 and readyk_i = 0, datak_o and validk_o SHALL remain stable.
REQ-021 The channel not selected SHALL never be written by an input transfer.
REQ-022 countk_o SHALL increment by 1 on each channel-k output transfer, wrap from 2^cnt_w-1 to 0, and have no saturation or overflow flag.
REQ-023 Output transfers on both channels in the same cycle SHALL update both counters independently.
REQ-024 Per-channel order SHALL be preserved; no ordering is guaranteed between channels.
REQ-025 select_i SHALL be ignored when valid_i = 0.

Reset
REQ-026 When rst_i = 0 at a rising edge, both slots SHALL go EMPTY, valid0_o = valid1_o = 0, data0_o = data1_o = 0, and count0_o = count1_o = 0.
REQ-027 Reset SHALL take priority over any simultaneous transfer; in-flight slot contents SHALL be discarded.
REQ-028 ready_o during reset SHALL follow REQ-016 using the reset-cleared slot state; no input transfer SHALL take effect at a reset edge.

Structure
REQ-029 No shared package; the EMPTY/FULL encoding SHALL be local to the slot module, and size and cnt_w are the only parameters.
REQ-030 One sub-module, demux_out_slot, SHALL implement a single slot plus its counter and be instantiated twice.
REQ-031 The top level SHALL contain only select decode and ready_o logic.

Verification
REQ-032 Reset, then valid_i=1, select_i=0, data_i=32'hA5A5_0001 -> ready_o=1; next cycle valid0_o=1, data0_o=32'hA5A5_0001, valid1_o=0.
REQ-033 Hold ready1_i=0 and fill channel 1 -> valid_i with select_i=1 gives ready_o=0; switching to select_i=0 gives ready_o=1 and channel 0 is accepted.
REQ-034 Channel 0 FULL with ready0_i=1 and a new input to channel 0 each cycle for 4 cycles -> ready_o=1 throughout, 4 values emerge in order back-to-back, count0_o=4.
REQ-035 Use cnt_w=2 and complete 5 transfers on channel 1 -> count1_o sequence 1,2,3,0,1.
REQ-036 Both slots FULL, then rst_i=0 for one cycle with valid_i=1 -> valid0_o=valid1_o=0, both counts 0, and no data accepted.
REQ-037 Stall ready0_i=0 for 3 cycles with channel 0 FULL -> data0_o stable; count0_o increments exactly once after ready0_i returns to 1.
